// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Command-frame controller behind a UART receiver.
//               Assembles 5-byte frames {A5, CMD, ADDR, DATA, CHK} from the
//               receiver byte stream, validates the checksum and command, and
//               issues one write or one read on a register-file port. Read
//               data is returned on a valid/ready response channel.
//
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               rx_data[7:0], rx_done    - received byte + one-cycle strobe
//               wr_en, wr_addr, wr_data  - register-file write strobe/address/data
//               rd_en, rd_addr           - register-file read strobe/address
//               rd_data[7:0]             - read data, valid the cycle after rd_en
//               rsp_valid, rsp_data      - pending response byte (held until ready)
//               rsp_ready                - consumer accepts the response
//               busy                     - a frame is being assembled
//               chk_err, cmd_err,
//               tout_err, ovf_err        - one-cycle error pulses
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 8680
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       rsp_ready,
    output logic       busy,
    output logic       chk_err,
    output logic       cmd_err,
    output logic       tout_err,
    output logic       ovf_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0]  c_ST_IDLE   = 3'd0;
    localparam logic [2:0]  c_ST_CMD    = 3'd1;
    localparam logic [2:0]  c_ST_ADDR   = 3'd2;
    localparam logic [2:0]  c_ST_DATA   = 3'd3;
    localparam logic [2:0]  c_ST_CHK    = 3'd4;

    localparam logic [7:0]  c_HDR       = 8'hA5;
    localparam logic [7:0]  c_CMD_WR    = 8'h01;
    localparam logic [7:0]  c_CMD_RD    = 8'h02;

    // Counter value at which the frame is abandoned (TIMEOUT_CYC cycles of
    // silence after the last accepted byte).
    localparam logic [31:0] c_TOUT_LAST = 32'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [31:0] r_cnt;
    logic [7:0]  r_cmd;
    logic [7:0]  r_addr;
    logic [7:0]  r_data;
    logic        r_wr_en;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_rd_en;
    logic [7:0]  r_rd_addr;
    logic        r_rd_pend;   // rd_en was high last cycle: rd_data is valid now
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_data;
    logic        r_busy;
    logic        r_chk_err;
    logic        r_cmd_err;
    logic        r_tout_err;
    logic        r_ovf_err;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    logic [2:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic [7:0]  w_cmd_nxt;
    logic [7:0]  w_addr_nxt;
    logic [7:0]  w_data_nxt;
    logic        w_wr_en_nxt;
    logic [7:0]  w_wr_addr_nxt;
    logic [7:0]  w_wr_data_nxt;
    logic        w_rd_en_nxt;
    logic [7:0]  w_rd_addr_nxt;
    logic        w_rsp_valid_nxt;
    logic [7:0]  w_rsp_data_nxt;
    logic        w_chk_err_nxt;
    logic        w_cmd_err_nxt;
    logic        w_tout_err_nxt;
    logic        w_ovf_err_nxt;

    logic [7:0]  w_sum;
    logic        w_tout;
    logic        w_rsp_blocked;

    // 8-bit running sum; the carry is intentionally dropped.
    assign w_sum         = r_cmd + r_addr + r_data;

    // A byte in the same cycle as the boundary wins over the timeout.
    assign w_tout        = (r_state != c_ST_IDLE) && !rx_done && (r_cnt == c_TOUT_LAST);

    // A new read would overwrite a response the consumer has not yet taken.
    assign w_rsp_blocked = r_rsp_valid && !rsp_ready;

    // ------------------------------------------------------------------------
    // Frame FSM, timeout counter and response channel
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_wr_en_nxt     = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_rd_en_nxt     = 1'b0;
        w_rd_addr_nxt   = r_rd_addr;
        w_chk_err_nxt   = 1'b0;
        w_cmd_err_nxt   = 1'b0;
        w_tout_err_nxt  = 1'b0;
        w_ovf_err_nxt   = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;

        if ((r_state == c_ST_IDLE) || rx_done || w_tout) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 32'd1;
        end

        if (w_tout) begin
            w_state_nxt    = c_ST_IDLE;
            w_tout_err_nxt = 1'b1;
        end else if (rx_done) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (rx_data == c_HDR) begin
                        w_state_nxt = c_ST_CMD;
                    end
                end
                c_ST_CMD: begin
                    w_cmd_nxt   = rx_data;
                    w_state_nxt = c_ST_ADDR;
                end
                c_ST_ADDR: begin
                    w_addr_nxt  = rx_data;
                    w_state_nxt = c_ST_DATA;
                end
                c_ST_DATA: begin
                    w_data_nxt  = rx_data;
                    w_state_nxt = c_ST_CHK;
                end
                c_ST_CHK: begin
                    w_state_nxt = c_ST_IDLE;
                    if (rx_data != w_sum) begin
                        w_chk_err_nxt = 1'b1;
                    end else if (r_cmd == c_CMD_WR) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = r_data;
                    end else if (r_cmd == c_CMD_RD) begin
                        if (w_rsp_blocked) begin
                            w_ovf_err_nxt = 1'b1;
                        end else begin
                            w_rd_en_nxt   = 1'b1;
                            w_rd_addr_nxt = r_addr;
                        end
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end

        // Frame length guarantees a capture never coincides with a pending
        // response, so capture simply takes precedence over the handshake.
        if (r_rd_pend) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_data_nxt  = rd_data;
        end else if (r_rsp_valid && rsp_ready) begin
            w_rsp_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_pend   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_chk_err   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_tout_err  <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_rd_pend   <= r_rd_en;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_busy      <= (w_state_nxt != c_ST_IDLE);
            r_chk_err   <= w_chk_err_nxt;
            r_cmd_err   <= w_cmd_err_nxt;
            r_tout_err  <= w_tout_err_nxt;
            r_ovf_err   <= w_ovf_err_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign chk_err   = r_chk_err;
    assign cmd_err   = r_cmd_err;
    assign tout_err  = r_tout_err;
    assign ovf_err   = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Scoreboard bench for uart_cmd_ctrl. Stimulus pushes the
//               expected DUT events into a queue; an independent monitor pops
//               and compares every event the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int unsigned T = 20;

    localparam int c_EV_WR   = 1;
    localparam int c_EV_RD   = 2;
    localparam int c_EV_RSP  = 3;
    localparam int c_EV_CHK  = 4;
    localparam int c_EV_CMD  = 5;
    localparam int c_EV_TOUT = 6;
    localparam int c_EV_OVF  = 7;

    typedef struct {
        int         kind;
        logic [7:0] a;
        logic [7:0] b;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [7:0] rd_data = 8'hEE;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ready = 1'b0;
    logic       busy;
    logic       chk_err;
    logic       cmd_err;
    logic       tout_err;
    logic       ovf_err;

    logic [7:0] rd_val = 8'h00;
    ev_t        exp_q[$];
    int         tests = 0;
    int         fails = 0;

    uart_cmd_ctrl #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .busy(busy), .chk_err(chk_err), .cmd_err(cmd_err),
        .tout_err(tout_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    // Register-file model: data for a read is valid only in the cycle after
    // rd_en; otherwise a poison value is driven.
    always @(posedge clk) rd_data <= rd_en ? rd_val : 8'hEE;

    // ---------------------------------------------------------------- checks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [7:0] a, input logic [7:0] b);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: got kind %0d (%0h,%0h), expected none", kind, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                fails++;
                $display("FAIL event: got kind %0d (%0h,%0h), expected kind %0d (%0h,%0h)",
                         kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en)                  observe(c_EV_WR,   wr_addr,  wr_data);
            if (rd_en)                  observe(c_EV_RD,   rd_addr,  8'h00);
            if (rsp_valid && rsp_ready) observe(c_EV_RSP,  rsp_data, 8'h00);
            if (chk_err)                observe(c_EV_CHK,  8'h00,    8'h00);
            if (cmd_err)                observe(c_EV_CMD,  8'h00,    8'h00);
            if (tout_err)               observe(c_EV_TOUT, 8'h00,    8'h00);
            if (ovf_err)                observe(c_EV_OVF,  8'h00,    8'h00);
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    function automatic logic [31:0] all_outs();
        return {wr_en, wr_addr, wr_data, rd_en, rd_addr} | 32'(rsp_data)
             | 32'({rsp_valid, busy, chk_err, cmd_err, tout_err, ovf_err});
    endfunction

    initial begin
        int  k;
        logic stable;

        // Reset state
        repeat (3) tick();
        check("reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        tick();

        // Write frame, with latency and busy checks
        expect_ev(c_EV_WR, 8'h10, 8'h3C);
        send_byte(8'hA5);
        check("busy_after_hdr", 32'(busy), 32'h1);
        send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h4D);
        check("wr_en_cycle_n1", 32'(wr_en), 32'h1);
        check("busy_after_chk", 32'(busy), 32'h0);
        tick();
        check("wr_en_single", 32'(wr_en), 32'h0);
        check("wr_addr_held", 32'(wr_addr), 32'h10);

        // Read frame, response held for 50 cycles then accepted
        rd_val = 8'h99;
        expect_ev(c_EV_RD, 8'h20, 8'h00);
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        check("rd_en_cycle_n1", 32'(rd_en), 32'h1);
        tick();
        check("rsp_valid_n1", 32'(rsp_valid), 32'h0);
        tick();
        check("rsp_valid_n2", 32'(rsp_valid), 32'h1);
        check("rsp_data", 32'(rsp_data), 32'h99);
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!rsp_valid || rsp_data !== 8'h99) stable = 1'b0;
        end
        check("rsp_stable_50", 32'(stable), 32'h1);
        expect_ev(c_EV_RSP, 8'h99, 8'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_cleared", 32'(rsp_valid), 32'h0);

        // Checksum error, unknown command, junk before a frame
        expect_ev(c_EV_CHK, 8'h00, 8'h00);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h4E);
        expect_ev(c_EV_CMD, 8'h00, 8'h00);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        send_byte(8'h00);
        send_byte(8'hFF);
        expect_ev(c_EV_WR, 8'h10, 8'h3C);
        send_frame(8'h01, 8'h10, 8'h3C, 8'h4D);

        // Checksum wrap and 0xA5 as ordinary in-frame data
        expect_ev(c_EV_WR, 8'hF0, 8'h20);
        send_frame(8'h01, 8'hF0, 8'h20, 8'h11);
        expect_ev(c_EV_WR, 8'hA5, 8'hA5);
        send_frame(8'h01, 8'hA5, 8'hA5, 8'h4B);
        tick();

        // Timeout: tout_err exactly T edges after the edge that took 0x01
        expect_ev(c_EV_TOUT, 8'h00, 8'h00);
        send_byte(8'hA5);
        send_byte(8'h01);
        k = 0;
        for (int i = 1; i <= int'(T) + 5; i++) begin
            tick();
            if (tout_err) begin
                k = i;
                break;
            end
        end
        check("tout_latency", 32'(k), 32'(T));
        check("busy_after_tout", 32'(busy), 32'h0);
        tick();
        expect_ev(c_EV_WR, 8'h33, 8'h44);
        send_frame(8'h01, 8'h33, 8'h44, 8'h78);

        // Byte on the boundary cycle suppresses the timeout
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (T - 1) tick();
        expect_ev(c_EV_WR, 8'h10, 8'h3C);
        send_byte(8'h10);
        send_byte(8'h3C);
        send_byte(8'h4D);
        tick();

        // Overflow: second read while first response is still pending
        rd_val = 8'h11;
        expect_ev(c_EV_RD, 8'h30, 8'h00);
        send_frame(8'h02, 8'h30, 8'h00, 8'h32);
        repeat (3) tick();
        rd_val = 8'h22;
        expect_ev(c_EV_OVF, 8'h00, 8'h00);
        send_frame(8'h02, 8'h40, 8'h05, 8'h47);
        repeat (3) tick();
        check("ovf_rsp_kept", 32'({rsp_valid, rsp_data}), 32'h111);
        expect_ev(c_EV_RSP, 8'h11, 8'h00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset mid-frame discards the partial frame
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        rst = 1'b1;
        tick(); tick();
        check("midframe_reset_outputs", all_outs(), 32'h0);
        rst = 1'b0;
        tick();
        expect_ev(c_EV_WR, 8'h55, 8'h66);
        send_frame(8'h01, 8'h55, 8'h66, 8'hBC);

        repeat (5) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command-frame controller behind the UART receiver. It consumes the receiver's byte stream (8-bit data plus a one-cycle done strobe) and assembles 5-byte command frames. It validates each frame and sequences one write or one read access on a shared register-file port. Read results go to the UART transmit side through a valid/ready response channel.

## Interface
- `TIMEOUT_CYC`, default 8680: inter-byte timeout in clk cycles, about 2 byte times at 50 MHz / 115200 baud; minimum 2.
- `clk` input, 1 bit: system clock; all logic on the rising edge.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `rx_data` input, 8 bits: received byte; valid only while `rx_done`=1.
- `rx_done` input, 1 bit: one-cycle strobe, one received byte.
- `wr_en` output, 1 bit: one-cycle register-file write strobe.
- `wr_addr` output, 8 bits: write address; valid while `wr_en`=1.
- `wr_data` output, 8 bits: write data; valid while `wr_en`=1.
- `rd_en` output, 1 bit: one-cycle register-file read strobe.
- `rd_addr` output, 8 bits: read address; valid while `rd_en`=1.
- `rd_data` input, 8 bits: register-file read data; valid in the cycle after `rd_en`.
- `rsp_valid` output, 1 bit: response byte pending.
- `rsp_data` output, 8 bits: response byte; stable while `rsp_valid`=1.
- `rsp_ready` input, 1 bit: consumer accepts the response.
- `busy` output, 1 bit: 1 whenever the state is not IDLE.
- `chk_err` output, 1 bit: one-cycle pulse; checksum mismatch.
- `cmd_err` output, 1 bit: one-cycle pulse; unknown command.
- `tout_err` output, 1 bit: one-cycle pulse; frame abandoned by timeout.
- `ovf_err` output, 1 bit: one-cycle pulse; read dropped because a response was still pending.

## Operation
- Frame format, in byte order: HDR=0xA5, CMD, ADDR, DATA, CHK.
- CHK = (CMD + ADDR + DATA) mod 256; the 8-bit sum truncates and the carry is discarded.
- Commands:
  - CMD=0x01 is a write of DATA to ADDR.
  - CMD=0x02 is a read of ADDR; DATA is don't-care but is still included in CHK.
- FSM states are IDLE, CMD, ADDR, DATA, CHK. The only events are an `rx_done` strobe and a timeout.
  - IDLE: on `rx_done` with 0xA5 go to CMD. Any other byte is silently ignored and the state stays IDLE.
  - CMD, ADDR, DATA: each latches its byte on `rx_done`, then advances to the next state.
  - CHK: on `rx_done`, evaluate the frame and always return to IDLE.
- Frame evaluation in CHK, checked in this priority order:
  1. Checksum mismatch: pulse `chk_err`; no access.
  2. CMD not 0x01 and not 0x02: pulse `cmd_err`; no access.
  3. Write: pulse `wr_en` with `wr_addr`/`wr_data`.
  4. Read:
     - If `rsp_valid`=1 and `rsp_ready`=0 at the evaluating edge: pulse `ovf_err`; no `rd_en`.
     - Otherwise: pulse `rd_en` with `rd_addr`.
- A 0xA5 byte inside a frame is ordinary data; there is no resynchronisation on the header value.
- Timeout counter (32-bit):
  - Cleared on every `rx_done` and while in IDLE; increments each cycle otherwise.
  - If the counter equals TIMEOUT_CYC-1 at an edge with `rx_done`=0: go to IDLE and pulse `tout_err`.
  - If `rx_done`=1 in the same cycle, the byte wins and no timeout occurs.
- Response channel:
  - `rd_data` is captured into `rsp_data` and `rsp_valid` is set.
  - `rsp_valid` stays 1 and `rsp_data` stays stable until an edge with `rsp_ready`=1.
  - At that edge `rsp_valid` clears.
- Reset:
  - State goes to IDLE and the counter clears.
  - All outputs are 0: `wr_en`, `wr_addr`, `wr_data`, `rd_en`, `rd_addr`, `rsp_valid`, `rsp_data`, `busy`, and all `*_err`.
  - A partial frame or pending response is discarded.

## Timing
- Let edge N be the edge that samples `rx_done`=1 for the CHK byte.
- `wr_en`, `rd_en`, `chk_err`, `cmd_err`, `ovf_err` are high in cycle N+1 only. All outputs are registered.
- `rd_data` is sampled at edge N+2; `rsp_valid`=1 from cycle N+2 (after edge N+2) onward.
- `tout_err` is high for the single cycle following the timeout edge.
- `busy` rises the cycle after the HDR byte is accepted. It falls the cycle after CHK evaluation or timeout.
- Back-to-back frames: a new HDR may arrive in any cycle after edge N; no dead time is required.
- `wr_addr`/`wr_data`/`rd_addr` hold their last values after the strobe; they are not cleared.

## Test plan
- Write frame: A5 01 10 3C 4D → one `wr_en` pulse with `wr_addr`=0x10, `wr_data`=0x3C; no error pulses; `busy` low afterwards.
- Read frame: A5 02 20 00 22, register file returns 0x99.
  - Expect `rd_en` with `rd_addr`=0x20, then `rsp_valid`=1 and `rsp_data`=0x99.
  - Holding `rsp_ready`=0 for 50 cycles keeps `rsp_valid`/`rsp_data` stable.
  - `rsp_ready`=1 clears `rsp_valid`.
- Errors:
  - A5 01 10 3C 4E → `chk_err` pulse, no `wr_en`.
  - A5 07 00 00 07 → `cmd_err` pulse, no access.
  - Junk 00 FF before a valid frame is ignored and the frame is executed.
- Timeout: A5 01, then no `rx_done` → `tout_err` exactly TIMEOUT_CYC cycles after the 01 strobe, and state is IDLE.
  - A following full write frame executes normally.
  - A byte arriving on the boundary cycle suppresses the timeout.
- Overflow: two read frames with `rsp_ready` held 0 → second frame gives `ovf_err` and no `rd_en`; `rsp_data` keeps the first value.
- Reset mid-frame: assert `rst` after A5 01 10, release, send a valid write → all outputs 0 during reset and only the new frame executes.
